// File: rtl/bitstream_fetcher.sv
// Bit-buffer front end for the arithmetic decoder: prefetches 9-bit words and serves 0..MAX_RD bit reads MSB-first.
// Optional statistics counters are built when BITSTREAM_FETCHER_STATS_EN is defined.
module bitstream_fetcher #(
  parameter int unsigned WORD_W = 9,
  parameter int unsigned BUF_W  = 32,
  parameter int unsigned MAX_RD = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         src_request,
  input  logic                         src_ack,
  input  logic [WORD_W-1:0]            src_data,
  input  logic                         src_eos,
  input  logic                         rd_req,
  input  logic [3:0]                   rd_len,
  output logic                         rd_ready,
  output logic                         rd_valid,
  output logic [MAX_RD-1:0]            rd_data,
  output logic [$clog2(BUF_W+1)-1:0]   fill,
  output logic                         stream_end
`ifdef BITSTREAM_FETCHER_STATS_EN
  ,
  output logic [31:0]                  bits_consumed,
  output logic [15:0]                  words_fetched
`endif
);

  localparam int unsigned FILL_W = $clog2(BUF_W+1);
  localparam int unsigned LEN_W  = 4;

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT, F_EOS} fstate_t;

  fstate_t             fstate;
  logic [BUF_W-1:0]    bits_q;
  logic [FILL_W-1:0]   fill_q;
  logic                pend_q;
  logic [LEN_W-1:0]    pend_len_q;
  logic                src_request_q;
  logic                rd_ready_q;
  logic                rd_valid_q;
  logic [MAX_RD-1:0]   rd_data_q;
  logic                stream_end_q;

  logic [LEN_W-1:0]    len_in;
  logic                accept;
  logic                cur_act;
  logic [LEN_W-1:0]    cur_len;
  logic                avail;
  logic                serve;
  logic [FILL_W-1:0]   take;
  logic [FILL_W-1:0]   fill_base;
  logic [FILL_W-1:0]   fill_next;
  logic                append;
  logic                eos_next;
  logic [BUF_W-1:0]    word_ext;
  logic [BUF_W-1:0]    bits_next;
  logic [MAX_RD-1:0]   rd_bits;

  // Read serving and buffer datapath; bits below fill are always zero, so EOS padding comes for free.
  always_comb begin
    len_in    = (rd_len > LEN_W'(MAX_RD)) ? LEN_W'(MAX_RD) : rd_len;
    accept    = rd_req & rd_ready_q;
    cur_act   = accept | pend_q;
    cur_len   = pend_q ? pend_len_q : len_in;
    avail     = fill_q >= FILL_W'(cur_len);
    serve     = cur_act & (avail | (fstate == F_EOS));
    take      = '0;
    if (serve) take = avail ? FILL_W'(cur_len) : fill_q;
    fill_base = fill_q - take;
    append    = (fstate == F_WAIT) & src_ack & ~src_eos;
    eos_next  = (fstate == F_EOS) | ((fstate == F_WAIT) & src_eos);
    word_ext  = {src_data, {(BUF_W-WORD_W){1'b0}}};
    bits_next = bits_q << take;
    fill_next = fill_base;
    if (append) begin
      bits_next = bits_next | (word_ext >> fill_base);
      fill_next = fill_base + FILL_W'(WORD_W);
    end
    rd_bits   = bits_q[BUF_W-1 -: MAX_RD] >> (LEN_W'(MAX_RD) - cur_len);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fstate        <= F_IDLE;
      bits_q        <= '0;
      fill_q        <= '0;
      pend_q        <= 1'b0;
      pend_len_q    <= '0;
      src_request_q <= 1'b0;
      rd_ready_q    <= 1'b1;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      stream_end_q  <= 1'b0;
    end else begin
      bits_q        <= bits_next;
      fill_q        <= fill_next;
      rd_valid_q    <= serve;
      rd_ready_q    <= ~(cur_act & ~serve);
      stream_end_q  <= stream_end_q | (eos_next & (fill_next == '0));
      src_request_q <= 1'b0;
      if (serve) begin
        rd_data_q <= rd_bits;
        pend_q    <= 1'b0;
      end else if (accept) begin
        pend_q     <= 1'b1;
        pend_len_q <= len_in;
      end
      // Fetch FSM: one outstanding request, prefetch while a whole word still fits.
      case (fstate)
        F_IDLE: begin
          if (fill_q <= FILL_W'(BUF_W-WORD_W)) begin
            fstate        <= F_REQ;
            src_request_q <= 1'b1;
          end
        end
        F_REQ:  fstate <= F_WAIT;
        F_WAIT: begin
          if (src_eos)      fstate <= F_EOS;
          else if (src_ack) fstate <= F_IDLE;
        end
        F_EOS:  fstate <= F_EOS;
        default: fstate <= F_IDLE;
      endcase
    end
  end

`ifdef BITSTREAM_FETCHER_STATS_EN
  logic [31:0] bits_consumed_q;
  logic [15:0] words_fetched_q;

  // Zero-padded bits count as consumed; both counters wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bits_consumed_q <= '0;
      words_fetched_q <= '0;
    end else begin
      if (serve)  bits_consumed_q <= bits_consumed_q + 32'(cur_len);
      if (append) words_fetched_q <= words_fetched_q + 16'd1;
    end
  end

  assign bits_consumed = bits_consumed_q;
  assign words_fetched = words_fetched_q;
`else
  // Statistics counters are not built in this configuration.
`endif

  assign src_request = src_request_q;
  assign rd_ready    = rd_ready_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign fill        = fill_q;
  assign stream_end  = stream_end_q;

endmodule
